// File: rtl/fir4x_serializer.sv
// Buffers 4-sample FIR output blocks and serializes them onto a valid/ready stream; first sample
// appears one clock after capture, out_data holds under backpressure, and blocks arriving while full are dropped.
module fir4x_serializer #(
   parameter int LAT   = 4,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   blk_in_valid,
   input  logic signed [31:0]     y4k,
   input  logic signed [31:0]     y4k1,
   input  logic signed [31:0]     y4k2,
   input  logic signed [31:0]     y4k3,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [31:0]     out_data,
   output logic [1:0]             out_idx,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [LAT-1:0]     vdly;
   logic               cap_valid;
   logic               full;
   logic               hs;
   logic               pop;
   logic               wr;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic signed [31:0] mem [DEPTH][4];

   assign cap_valid = vdly[LAT-1];
   assign full      = (level == LW'(DEPTH));
   assign out_valid = (level != '0);
   assign hs        = out_valid & out_ready;
   assign pop       = hs & (out_idx == 2'd3);
   // A pop in the same cycle frees the slot being read, so a full buffer still accepts the block.
   assign wr        = cap_valid & (~full | pop);
   assign out_data  = out_valid ? mem[rd_ptr][out_idx] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vdly     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         out_idx  <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         vdly[0] <= blk_in_valid;
         for (int i = 1; i < LAT; i++) begin
            vdly[i] <= vdly[i-1];
         end
         if (wr) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (hs) begin
            out_idx <= out_idx + 2'd1;
         end
         if (wr && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !wr) begin
            level <= level - LW'(1);
         end
         if (cap_valid && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wr_ptr][0] <= y4k;
         mem[wr_ptr][1] <= y4k1;
         mem[wr_ptr][2] <= y4k2;
         mem[wr_ptr][3] <= y4k3;
      end
   end

endmodule

// File: tb/tb_fir4x_serializer.sv
// Bench for fir4x_serializer: directed vector table, corner-case sequences and a queue-based reference model.
module tb_fir4x_serializer;
   localparam int LAT   = 4;
   localparam int DEPTH = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   blk_in_valid;
   logic                   out_ready;
   logic                   out_valid;
   logic                   overflow;
   logic signed [31:0]     y4k, y4k1, y4k2, y4k3, out_data;
   logic [1:0]             out_idx;
   logic [$clog2(DEPTH):0] level;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a queue of whole blocks plus a list of cycles at which captures are due.
   typedef logic [3:0][31:0] blk_t;
   blk_t mq[$];
   int   due[$];
   int   mcyc;
   int   midx;
   bit   movf;

   typedef struct {
      bit bv;
      int y0, y1, y2, y3;
      bit rdy;
      bit ev;
      int ed, ei, el;
   } vec_t;
   vec_t tbl[25];

   int  got[$];
   int  pat[4];
   bit  sbv;
   int  sv;

   fir4x_serializer #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .blk_in_valid(blk_in_valid),
      .y4k(y4k),
      .y4k1(y4k1),
      .y4k2(y4k2),
      .y4k3(y4k3),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_idx(out_idx),
      .level(level),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit bv, int y0, int y1, int y2, int y3, bit rdy,
                               bit ev, int ed, int ei, int el);
      vec_t r;
      r.bv = bv; r.y0 = y0; r.y1 = y1; r.y2 = y2; r.y3 = y3; r.rdy = rdy;
      r.ev = ev; r.ed = ed; r.ei = ei; r.el = el;
      return r;
   endfunction

   task automatic model_clear();
      mq.delete();
      due.delete();
      mcyc = 0;
      midx = 0;
      movf = 1'b0;
   endtask

   task automatic drive(input bit bv, input int a, input int b, input int c, input int d,
                        input bit rdy);
      blk_in_valid = bv;
      y4k = a; y4k1 = b; y4k2 = c; y4k3 = d;
      out_ready = rdy;
   endtask

   // Called at a falling edge: check outputs against the model, drive, clock, update the model.
   task automatic step(input bit bv, input int a, input int b, input int c, input int d,
                       input bit rdy);
      bit   ev, cap, hs, pop;
      blk_t nb;
      ev = (mq.size() > 0);
      chk("out_valid", out_valid, ev);
      chk("level", level, mq.size());
      chk("overflow", overflow, movf);
      chk("out_idx", out_idx, midx);
      if (ev) chk("out_data", out_data, int'($signed(mq[0][midx])));
      drive(bv, a, b, c, d, rdy);
      @(posedge clk);
      cap = (due.size() > 0) && (due[0] == mcyc);
      if (cap) void'(due.pop_front());
      if (bv) due.push_back(mcyc + LAT);
      hs  = ev && rdy;
      pop = hs && (midx == 3);
      if (pop) void'(mq.pop_front());
      if (cap) begin
         if (mq.size() < DEPTH) begin
            nb[0] = a; nb[1] = b; nb[2] = c; nb[3] = d;
            mq.push_back(nb);
         end else begin
            movf = 1'b1;
         end
      end
      if (hs) midx = (midx + 1) % 4;
      mcyc++;
      @(negedge clk);
   endtask

   // Asserts reset at a falling edge, checks the outputs clear without a clock, releases at the next falling edge.
   task automatic do_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_data", out_data, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by t=%0t, want finish", $time);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      model_clear();
      pat[0] = -5; pat[1] = 2147483647; pat[2] = 32'sh80000000; pat[3] = 0;

      // single block, then the same block under backpressure
      tbl[0]  = mk(1,  0,  0,  0,  0, 1,  0,  0, 0, 0);
      tbl[1]  = mk(0,  0,  0,  0,  0, 1,  0,  0, 0, 0);
      tbl[2]  = mk(0,  0,  0,  0,  0, 1,  0,  0, 0, 0);
      tbl[3]  = mk(0,  0,  0,  0,  0, 1,  0,  0, 0, 0);
      tbl[4]  = mk(0, 10, 20, 30, 40, 1,  0,  0, 0, 0);
      tbl[5]  = mk(0,  0,  0,  0,  0, 1,  1, 10, 0, 1);
      tbl[6]  = mk(0,  0,  0,  0,  0, 1,  1, 20, 1, 1);
      tbl[7]  = mk(0,  0,  0,  0,  0, 1,  1, 30, 2, 1);
      tbl[8]  = mk(0,  0,  0,  0,  0, 1,  1, 40, 3, 1);
      tbl[9]  = mk(0,  0,  0,  0,  0, 1,  0,  0, 0, 0);
      tbl[10] = mk(1,  0,  0,  0,  0, 0,  0,  0, 0, 0);
      tbl[11] = mk(0,  0,  0,  0,  0, 0,  0,  0, 0, 0);
      tbl[12] = mk(0,  0,  0,  0,  0, 0,  0,  0, 0, 0);
      tbl[13] = mk(0,  0,  0,  0,  0, 0,  0,  0, 0, 0);
      tbl[14] = mk(0, 10, 20, 30, 40, 0,  0,  0, 0, 0);
      tbl[15] = mk(0,  0,  0,  0,  0, 0,  1, 10, 0, 1);
      tbl[16] = mk(0,  0,  0,  0,  0, 0,  1, 10, 0, 1);
      tbl[17] = mk(0,  0,  0,  0,  0, 0,  1, 10, 0, 1);
      tbl[18] = mk(0,  0,  0,  0,  0, 0,  1, 10, 0, 1);
      tbl[19] = mk(0,  0,  0,  0,  0, 0,  1, 10, 0, 1);
      tbl[20] = mk(0,  0,  0,  0,  0, 1,  1, 10, 0, 1);
      tbl[21] = mk(0,  0,  0,  0,  0, 1,  1, 20, 1, 1);
      tbl[22] = mk(0,  0,  0,  0,  0, 1,  1, 30, 2, 1);
      tbl[23] = mk(0,  0,  0,  0,  0, 1,  1, 40, 3, 1);
      tbl[24] = mk(0,  0,  0,  0,  0, 1,  0,  0, 0, 0);

      @(negedge clk);
      do_reset();

      for (int i = 0; i < 25; i++) begin
         chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
         chk($sformatf("tbl%0d_idx", i), out_idx, tbl[i].ei);
         chk($sformatf("tbl%0d_level", i), level, tbl[i].el);
         chk($sformatf("tbl%0d_ovf", i), overflow, 0);
         drive(tbl[i].bv, tbl[i].y0, tbl[i].y1, tbl[i].y2, tbl[i].y3, tbl[i].rdy);
         @(posedge clk);
         @(negedge clk);
      end

      // overflow: three back-to-back blocks into a two-block buffer with no draining
      do_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 2, 3, 4, 0);
      step(0, 5, 6, 7, 8, 0);
      step(0, 9, 10, 11, 12, 0);
      chk("ovf_level", level, 2);
      chk("ovf_flag", overflow, 1);
      got.delete();
      for (int c = 0; c < 10; c++) begin
         if (out_valid) got.push_back(int'(out_data));
         step(0, 0, 0, 0, 0, 1);
      end
      chk("ovf_count", got.size(), 8);
      for (int k = 0; k < got.size(); k++) chk("ovf_seq", got[k], k + 1);
      chk("ovf_sticky", overflow, 1);

      // full buffer: final pop of the head block coincides with a capture
      do_reset();
      got.delete();
      for (int c = 0; c < 20; c++) begin
         sbv = (c == 0) || (c == 1) || (c == 7);
         sv  = (c == 4) ? 100 : (c == 5) ? 200 : (c == 11) ? 300 : 0;
         if (c >= 8 && out_valid) got.push_back(int'(out_data));
         step(sbv, sv, sv + 1, sv + 2, sv + 3, c >= 8);
         if (c == 11) begin
            chk("pw_level", level, 2);
            chk("pw_ovf", overflow, 0);
         end
      end
      chk("pw_count", got.size(), 12);
      for (int k = 0; k < got.size(); k++) chk("pw_seq", got[k], 100 * (k / 4 + 1) + k % 4);

      // streaming one block every 4th cycle with extreme signed values
      do_reset();
      got.delete();
      for (int c = 0; c < 28; c++) begin
         if (out_valid) got.push_back(int'(out_data));
         step((c % 4 == 0) && (c < 20), pat[0], pat[1], pat[2], pat[3], 1);
         if (c + 1 >= 5 && c + 1 <= 24) begin
            chk("stream_valid", out_valid, 1);
            chk("stream_level_le1", int'(level <= 1), 1);
         end
      end
      chk("stream_ovf", overflow, 0);
      chk("stream_count", got.size(), 20);
      for (int k = 0; k < got.size(); k++) chk("stream_val", got[k], pat[k % 4]);

      // reset after two samples of a block, with another block still in flight
      do_reset();
      step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 7, 8, 9, 10, 1);
      step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("mid_idx_before", out_idx, 2);
      chk("mid_valid_before", out_valid, 1);
      do_reset();
      for (int c = 0; c < 10; c++) begin
         step(0, 0, 0, 0, 0, 1);
         chk("mid_quiet", out_valid, 0);
      end
      step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 55, 56, 57, 58, 1);
      chk("mid_new_first", out_data, 55);
      for (int c = 0; c < 5; c++) step(0, 0, 0, 0, 0, 1);

      // randomized traffic with decreasing downstream readiness
      for (int ph = 0; ph < 4; ph++) begin
         do_reset();
         for (int c = 0; c < 200; c++) begin
            step($urandom_range(0, 4) == 0, int'($urandom), int'($urandom), int'($urandom),
                 int'($urandom), $urandom_range(0, 3) >= ph);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fir4x_serializer.md
FIR4X_SERIALIZER -- requirements
Module: fir4x_serializer

Interface
REQ-001 SHALL have parameter LAT, default 4: FIR block latency in clocks from block input to y outputs.
REQ-002 SHALL have parameter DEPTH, default 2: block buffer depth in 4-sample blocks; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port blk_in_valid, input, 1 bit: asserted in the cycle a valid x4k..x4k3 block is presented to the FIR.
REQ-006 SHALL have ports y4k, y4k1, y4k2, y4k3, input, 32 bits signed each: the FIR parallel outputs.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds a valid serial sample.
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the sample.
REQ-009 SHALL have port out_data, output, 32 bits signed: the serial output sample.
REQ-010 SHALL have port out_idx, output, 2 bits: position (0..3) of out_data within its block.
REQ-011 SHALL have port level, output, clog2(DEPTH)+1 bits: number of blocks held.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a block is dropped.

Function
REQ-013 SHALL delay blk_in_valid through a LAT-stage shift register; the last stage (cap_valid) marks the cycle in which y4k..y4k3 belong to that block.
REQ-014 SHALL, when cap_valid=1 and the buffer is not full, write {y4k,y4k1,y4k2,y4k3} into the buffer at wr_ptr, then increment wr_ptr modulo DEPTH.
REQ-015 SHALL, when cap_valid=1 and level==DEPTH with no pop in the same cycle, drop the block, leave the buffer unchanged, and set overflow to 1.
REQ-016 SHALL accept the write when cap_valid=1, level==DEPTH and a pop occurs in the same cycle; level stays DEPTH and overflow is not set.
REQ-017 SHALL drive out_valid=1 exactly when level>0.
REQ-018 SHALL drive out_data as element out_idx of the block at rd_ptr; element 0 is y4k and element 3 is y4k3.
REQ-019 SHALL, on a handshake (out_valid and out_ready both 1), increment out_idx modulo 4.
REQ-020 SHALL pop the block at rd_ptr (rd_ptr+1 modulo DEPTH, level-1) on a handshake with out_idx==3.
REQ-021 SHALL update level by +1 on a write only, -1 on a pop only, and leave it unchanged on both or neither.
REQ-022 SHALL hold out_data and out_idx stable while out_valid=1 and out_ready=0.
REQ-023 SHALL have no effect when out_ready=1 while out_valid=0.
REQ-024 SHALL write to and read from a block in the same cycle only after the first serial sample of that block has appeared; there is no combinational bypass from y inputs to out_data.
REQ-025 SHALL emit the first sample of a block written into an empty buffer one clock after cap_valid.
REQ-026 SHALL pass sample values unmodified: no rounding, saturation or sign change.
REQ-027 SHALL wrap wr_ptr and rd_ptr at DEPTH; full is level==DEPTH and empty is level==0.

Reset
REQ-028 SHALL, while reset=1, immediately clear the valid delay line, wr_ptr, rd_ptr, out_idx, level and overflow, and drive out_valid=0 and out_data=0.
REQ-029 SHALL discard buffered blocks and in-flight valid bits when reset is asserted mid-operation; no partial block is emitted after reset is released.
REQ-030 SHALL clear overflow only by reset.
REQ-031 SHALL treat the first rising clk edge after reset is deasserted as a normal operating cycle.

Verification
REQ-032 SHALL pass the single-block test: blk_in_valid pulse at cycle 0, y inputs = 10,20,30,40 at cycle LAT=4, out_ready=1 -> out_valid at cycles 5-8 with out_data 10,20,30,40, out_idx 0..3, then level=0.
REQ-033 SHALL pass the backpressure test: same block, out_ready=0 for cycles 5-9 then 1 -> out_data holds 10 with out_idx=0 until cycle 10, then 20,30,40 follow on consecutive cycles.
REQ-034 SHALL pass the overflow test: out_ready=0, three blocks A=1..4, B=5..8, C=9..12 captured on consecutive cycles, DEPTH=2 -> level=2, overflow=1, then out_ready=1 emits 1..8 and C is absent.
REQ-035 SHALL pass the simultaneous pop/write test: full buffer, out_idx=3 handshake in the same cycle as cap_valid -> level remains 2, overflow=0, and the new block is emitted after the remaining block.
REQ-036 SHALL pass the streaming test: blk_in_valid=1 every 4th cycle, out_ready=1 -> continuous out_valid=1, level<=1, no overflow, with signed values (-5, 2147483647, -2147483648, 0) reproduced exactly.
REQ-037 SHALL pass the reset-mid-block test: reset asserted after 2 samples of a block are emitted -> out_valid=0 in the same cycle, level=0, and only new blocks appear after release.
